adc_sequencer: RTL and testbench

Digital controller sitting on the other side of the `adc` macro. It generates the `seq_*` phase timing and the `en_*` enables, and captures the serial `comp_out` decisions into an Madc-bit raw code. The code is presented to the readout logic over a valid/ready handshake. One instance drives one ADC, and all outputs are registered so the ADC's clock gates see glitch-free phases.

---
 rtl/adc_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_adc_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sequencer.sv
// adc_sequencer: phase/enable controller for one SAR-style ADC macro.
// Drives the INIT -> SAMP -> (COMP, UPDATE) x Madc -> DONE sequence and
// gathers the serial comparator decisions into an MSB-first raw code.
// The code is then handed to the readout logic over a valid/ready handshake.
// Every output comes straight from a flop, so the ADC clock gates see
// glitch-free phases.
module adc_sequencer #(
    parameter int Madc        = 17,
    parameter int SAMP_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cont,
    input  logic [5:0]      en_cfg,
    input  logic            comp_out,
    output logic            seq_init,
    output logic            seq_samp,
    output logic            seq_comp,
    output logic            seq_update,
    output logic            en_init,
    output logic            en_samp_p,
    output logic            en_samp_n,
    output logic            en_comp,
    output logic            en_update_p,
    output logic            en_update_n,
    output logic            busy,
    output logic [Madc-1:0] data,
    output logic            data_valid,
    input  logic            data_ready
);

    // Counter widths. Each is at least 1 bit so that degenerate parameter
    // values still elaborate.
    localparam int KW = (Madc > 1) ? $clog2(Madc) : 1;
    localparam int SW = (SAMP_CYCLES > 1) ? $clog2(SAMP_CYCLES) : 1;

    localparam logic [KW-1:0] K_LAST = KW'(Madc - 1);
    localparam logic [SW-1:0] S_LOAD = SW'(SAMP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SAMP,
        S_COMP,
        S_UPDATE,
        S_DONE
    } state_e;

    // The four ADC phase strobes. In any state at most one of them is high.
    typedef struct packed {
        logic init;
        logic samp;
        logic comp;
        logic update;
    } seq_t;

    state_e          state_q,    state_d;
    logic [KW-1:0]   k_q,        k_d;
    logic [SW-1:0]   samp_cnt_q, samp_cnt_d;
    logic [5:0]      en_q,       en_d;
    logic [Madc-1:0] data_q,     data_d;
    seq_t            seq_q,      seq_d;
    logic            busy_q,     busy_d;
    logic            valid_q,    valid_d;

    // Next-state logic, counters, enable latch and bit capture
    always_comb begin
        // NOTE: every signal driven here gets a default first. Without a
        // default, a path that skips an assignment would infer a latch.
        state_d    = state_q;
        k_d        = k_q;
        samp_cnt_d = samp_cnt_q;
        en_d       = en_q;
        data_d     = data_q;

        case (state_q)
            S_IDLE: begin
                k_d    = '0;
                data_d = '0;
                if (start) begin
                    en_d    = en_cfg;
                    state_d = S_INIT;
                end
            end

            S_INIT: begin
                // Back-to-back conversions re-enter here without passing
                // through IDLE, so the bit index is also restarted here.
                k_d        = '0;
                samp_cnt_d = S_LOAD;
                state_d    = S_SAMP;
            end

            S_SAMP: begin
                if (samp_cnt_q == '0) begin
                    state_d = S_COMP;
                end else begin
                    samp_cnt_d = samp_cnt_q - SW'(1);
                end
            end

            S_COMP: begin
                // Decision k lands in bit Madc-1-k, so the first decision
                // ends up as the MSB.
                for (int i = 0; i < Madc; i++) begin
                    if (k_q == KW'(Madc - 1 - i)) begin
                        data_d[i] = comp_out;
                    end
                end
                state_d = S_UPDATE;
            end

            S_UPDATE: begin
                if (k_q == K_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = S_COMP;
                end
            end

            S_DONE: begin
                // Hold the result until the consumer takes it. In continuous
                // mode the old code stays visible and is overwritten bit by
                // bit during the next conversion.
                if (valid_q && data_ready) begin
                    state_d = cont ? S_INIT : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the state about to be entered so
    // that they line up with state_q
    always_comb begin
        seq_d        = '0;
        seq_d.init   = (state_d == S_INIT);
        seq_d.samp   = (state_d == S_SAMP);
        seq_d.comp   = (state_d == S_COMP);
        seq_d.update = (state_d == S_UPDATE);
        busy_d       = (state_d != S_IDLE);
        valid_d      = (state_d == S_DONE);
    end

    // State and output registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            samp_cnt_q <= '0;
            en_q       <= '0;
            // NOTE: data is a plain register, not a memory array, so it can
            // be reset along with everything else at no real cost.
            data_q     <= '0;
            seq_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every flop samples the
            // pre-edge value of every other flop.
            state_q    <= state_d;
            k_q        <= k_d;
            samp_cnt_q <= samp_cnt_d;
            en_q       <= en_d;
            data_q     <= data_d;
            seq_q      <= seq_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    // en_cfg bit order: {update_n, update_p, comp, samp_n, samp_p, init}
    assign en_init     = en_q[0];
    assign en_samp_p   = en_q[1];
    assign en_samp_n   = en_q[2];
    assign en_comp     = en_q[3];
    assign en_update_p = en_q[4];
    assign en_update_n = en_q[5];

    assign seq_init    = seq_q.init;
    assign seq_samp    = seq_q.samp;
    assign seq_comp    = seq_q.comp;
    assign seq_update  = seq_q.update;

    assign busy        = busy_q;
    assign data        = data_q;
    assign data_valid  = valid_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer. It uses table-driven conversions,
// randomized conversions scored against a decision-list model, and
// hand-written sequences for continuous mode, an ignored start and an
// asynchronous reset.
module tb_adc_sequencer;

    localparam int MADC = 17;
    localparam int SAMP = 4;
    localparam int LAT  = 1 + SAMP + 2 * MADC;   // accept edge -> data_valid
    localparam int PER  = LAT + 1;               // continuous-mode period

    logic            clk;
    logic            rst;
    logic            start;
    logic            cont;
    logic [5:0]      en_cfg;
    logic            comp_out;
    logic            seq_init, seq_samp, seq_comp, seq_update;
    logic            en_init, en_samp_p, en_samp_n, en_comp, en_update_p, en_update_n;
    logic            busy;
    logic [MADC-1:0] data;
    logic            data_valid;
    logic            data_ready;

    int checks   = 0;
    int failures = 0;

    // Comparator decisions, in the order the ADC produces them.
    bit dec[MADC];
    int comp_idx = 0;

    typedef struct {
        logic [5:0]      cfg;
        logic [MADC-1:0] pat;
        int              rdy_delay;
        bit              mess_en;
        logic [MADC-1:0] exp_data;
        logic [5:0]      exp_en;
    } vec_t;

    vec_t tbl[4];

    adc_sequencer #(.Madc(MADC), .SAMP_CYCLES(SAMP)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cont       (cont),
        .en_cfg     (en_cfg),
        .comp_out   (comp_out),
        .seq_init   (seq_init),
        .seq_samp   (seq_samp),
        .seq_comp   (seq_comp),
        .seq_update (seq_update),
        .en_init    (en_init),
        .en_samp_p  (en_samp_p),
        .en_samp_n  (en_samp_n),
        .en_comp    (en_comp),
        .en_update_p(en_update_p),
        .en_update_n(en_update_n),
        .busy       (busy),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] en_bus();
        return {en_update_n, en_update_p, en_comp, en_samp_n, en_samp_p, en_init};
    endfunction

    function automatic logic [3:0] seq_bus();
        return {seq_init, seq_samp, seq_comp, seq_update};
    endfunction

    // Reference model: the raw code is the decision list read as a binary
    // number, with the earliest decision as the most significant digit.
    function automatic logic [MADC-1:0] model_code();
        logic [MADC-1:0] acc = '0;
        for (int i = 0; i < MADC; i++) acc = (acc << 1) | MADC'(dec[i]);
        return acc;
    endfunction

    task automatic load_pat(input logic [MADC-1:0] pat);
        for (int i = 0; i < MADC; i++) dec[i] = pat[MADC-1-i];
    endtask

    // Advance one clock and settle just past the edge. This plays the ADC:
    // during each COMP cycle it presents the next decision.
    task automatic tick();
        @(posedge clk);
        #1;
        if (seq_init) comp_idx = 0;
        if (seq_comp) begin
            if (comp_idx < MADC) comp_out = dec[comp_idx];
            comp_idx++;
        end
    endtask

    // One full conversion from IDLE with cont=0. The decisions come from dec[].
    task automatic run_conv(input string tag, input logic [5:0] cfg, input int rdy_delay,
                            input bit mess_en, input bit start_in_comp5,
                            input logic [MADC-1:0] exp_data, input logic [5:0] exp_en);
        int edges, n_init, n_samp, n_comp, n_upd, onehot_bad, en_bad;
        int valid_n, data_bad, seq_bad;
        edges = 0; n_init = 0; n_samp = 0; n_comp = 0; n_upd = 0;
        onehot_bad = 0; en_bad = 0; valid_n = 0; data_bad = 0; seq_bad = 0;
        cont       = 1'b0;
        en_cfg     = cfg;
        data_ready = (rdy_delay == 0);
        start      = 1'b1;
        tick();                                   // accept edge E0
        start = 1'b0;
        while (!data_valid && edges < 4 * LAT) begin
            n_init += int'(seq_init);
            n_samp += int'(seq_samp);
            n_comp += int'(seq_comp);
            n_upd  += int'(seq_update);
            if ($countones(seq_bus()) != 1) onehot_bad++;
            if (en_bus() !== exp_en) en_bad++;
            if (!busy) onehot_bad++;
            if (mess_en && seq_samp) en_cfg = 6'b000000;
            start = start_in_comp5 && seq_comp && (comp_idx == 5);
            tick();
            edges++;
        end
        start = 1'b0;
        check({tag, " latency"}, edges, LAT);
        check({tag, " first data"}, data, exp_data);
        check({tag, " seq_init cycles"}, n_init, 1);
        check({tag, " seq_samp cycles"}, n_samp, SAMP);
        check({tag, " seq_comp pulses"}, n_comp, MADC);
        check({tag, " seq_update pulses"}, n_upd, MADC);
        check({tag, " one-hot/busy violations"}, onehot_bad, 0);
        while (data_valid && valid_n < 4 * LAT) begin
            valid_n++;
            if (data !== exp_data) data_bad++;
            if (seq_bus() !== 4'b0000 || !busy || en_bus() !== exp_en) seq_bad++;
            data_ready = (valid_n > rdy_delay);
            tick();
        end
        check({tag, " en stability"}, en_bad, 0);
        check({tag, " valid cycles"}, valid_n, rdy_delay + 1);
        check({tag, " data held"}, data_bad, 0);
        check({tag, " done-phase outputs"}, seq_bad, 0);
        check({tag, " idle after transfer"}, {busy, data_valid, seq_bus()}, 6'b0);
    endtask

    initial begin : main
        logic [MADC-1:0] exp_code;
        logic [5:0]      cfg;
        int              found, t, busy_low, init_miss, data_bad, done;
        bit              prev_valid;
        int              rises[$];

        rst = 1'b0; start = 1'b0; cont = 1'b0; en_cfg = '0;
        comp_out = 1'b0; data_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset seq", seq_bus(), 4'b0);
        check("reset en", en_bus(), 6'b0);
        check("reset busy/valid", {busy, data_valid}, 2'b0);
        check("reset data", data, 0);
        rst = 1'b0;
        tick();
        tick();
        check("idle busy", busy, 1'b0);

        // Table-driven conversions
        tbl[0] = '{6'b000001, 17'h15555,  0, 1'b0, 17'h15555, 6'b000001};
        tbl[1] = '{6'b101011, 17'h0A5A5,  0, 1'b1, 17'h0A5A5, 6'b101011};
        tbl[2] = '{6'b110100, 17'h1FFFF, 10, 1'b0, 17'h1FFFF, 6'b110100};
        tbl[3] = '{6'b010010, 17'h00001,  2, 1'b0, 17'h00001, 6'b010010};
        for (int v = 0; v < 4; v++) begin
            load_pat(tbl[v].pat);
            run_conv($sformatf("vec%0d", v), tbl[v].cfg, tbl[v].rdy_delay,
                     tbl[v].mess_en, 1'b0, tbl[v].exp_data, tbl[v].exp_en);
            tick();
        end

        // Randomized conversions scored against the decision-list model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < MADC; i++) dec[i] = bit'($urandom_range(0, 1));
            cfg      = 6'($urandom);
            exp_code = model_code();
            run_conv($sformatf("rand%0d", r), cfg, int'($urandom_range(0, 4)),
                     1'b1, 1'b0, exp_code, cfg);
        end

        // A start pulse during the 5th COMP must be ignored
        load_pat(17'h12F0C);
        run_conv("ignored start", 6'b001100, 0, 1'b0, 1'b1, 17'h12F0C, 6'b001100);

        // Continuous mode: three back-to-back conversions
        load_pat(17'h0F0F3);
        cont = 1'b1; data_ready = 1'b1; en_cfg = 6'b011110; start = 1'b1;
        tick();
        start = 1'b0;
        t = 0; busy_low = 0; init_miss = 0; data_bad = 0; done = 0; prev_valid = 1'b0;
        while (!done && t < 8 * PER) begin
            if (prev_valid && rises.size() < 3 && !seq_init) init_miss++;
            if (data_valid) begin
                rises.push_back(t);
                if (data !== 17'h0F0F3) data_bad++;
                if (rises.size() == 3) cont = 1'b0;
            end else if (rises.size() == 3) begin
                done = 1;
            end
            if (!done && !busy) busy_low++;
            prev_valid = data_valid;
            tick();
            t++;
        end
        check("cont conversions", rises.size(), 3);
        check("cont first latency", (rises.size() > 0) ? rises[0] : -1, LAT);
        check("cont period 1", (rises.size() == 3) ? rises[1] - rises[0] : -1, PER);
        check("cont period 2", (rises.size() == 3) ? rises[2] - rises[1] : -1, PER);
        check("cont busy low cycles", busy_low, 0);
        check("cont init after transfer", init_miss, 0);
        check("cont data", data_bad, 0);
        check("cont ends idle", busy, 1'b0);

        // Asynchronous reset during UPDATE of bit 8
        tick();
        load_pat(17'h1ABCD);
        data_ready = 1'b1; en_cfg = 6'b111111; start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 4 * LAT && !found; n++) begin
            if (seq_update && comp_idx == 9) found = 1;
            else tick();
        end
        check("reached bit-8 update", found, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst seq", seq_bus(), 4'b0);
        check("async rst en", en_bus(), 6'b0);
        check("async rst busy/valid", {busy, data_valid}, 2'b0);
        check("async rst data", data, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("no partial transfer", {busy, data_valid}, 2'b0);
        load_pat(17'h0C3A5);
        run_conv("after reset", 6'b100001, 1, 1'b0, 1'b0, 17'h0C3A5, 6'b100001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
